gpt_data_reg: RTL and testbench



---
 rtl/gpt_data_reg.sv | 90 +++++++++
 tb/tb_gpt_data_reg.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gpt_data_reg.sv
// gpt_data_reg: four-entry general-purpose operand register file.
//   One synchronous write port loaded from the data bus, two independent
//   combinational read ports feeding the ALU operands, and all four
//   registers exposed continuously for the I/O and observation paths.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset, clears Q0-Q3, wins over WE
//   D          write data
//   WE         write enable (active-high)
//   add        write address, 0..3 -> Q0..Q3
//   cha, chb   read addresses for ports A and B
//   Q0-Q3      register contents, straight from the flops
//   B0-B3      data outputs, identical copies of Q0-Q3 (no enable, no high-Z)
//   Da, Db     read port data, Q[cha] / Q[chb]
//
// Build option:
//   GPT_DATAREG_BYPASS_EN  when defined, a read port whose address matches
//                          an active write (rst_n=1, WE=1) returns D directly
//                          instead of the old register contents. Q/B outputs
//                          are never forwarded.
module gpt_data_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             WE,
  input  logic [1:0]       add,
  input  logic [1:0]       cha,
  input  logic [1:0]       chb,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] B0,
  output logic [WIDTH-1:0] B1,
  output logic [WIDTH-1:0] B2,
  output logic [WIDTH-1:0] B3,
  output logic [WIDTH-1:0] Da,
  output logic [WIDTH-1:0] Db
);

  logic [WIDTH-1:0] regs [4];
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (WE) begin
      regs[add] <= D;
    end
  end

  assign Q0 = regs[0];
  assign Q1 = regs[1];
  assign Q2 = regs[2];
  assign Q3 = regs[3];

  assign B0 = regs[0];
  assign B1 = regs[1];
  assign B2 = regs[2];
  assign B3 = regs[3];

  always_comb begin
    mux_a = regs[cha];
    mux_b = regs[chb];
  end

`ifdef GPT_DATAREG_BYPASS_EN
  logic wr_active;
  assign wr_active = rst_n && WE;

  always_comb begin
    Da = mux_a;
    Db = mux_b;
    if (wr_active && (cha == add)) Da = D;
    if (wr_active && (chb == add)) Db = D;
  end
`else
  always_comb begin
    Da = mux_a;
    Db = mux_b;
  end
`endif

endmodule

// File: tb/tb_gpt_data_reg.sv
// tb_gpt_data_reg: directed self-checking bench for gpt_data_reg.
//   Inputs change 1 time unit after a rising edge; outputs are checked
//   there too, well away from the next active edge.
module tb_gpt_data_reg;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic       we;
  logic [1:0] add;
  logic [1:0] cha;
  logic [1:0] chb;
  logic [7:0] q0, q1, q2, q3;
  logic [7:0] b0, b1, b2, b3;
  logic [7:0] da, db;

  int unsigned checks;
  int unsigned failures;

  gpt_data_reg #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (d),
    .WE    (we),
    .add   (add),
    .cha   (cha),
    .chb   (chb),
    .Q0    (q0),
    .Q1    (q1),
    .Q2    (q2),
    .Q3    (q3),
    .B0    (b0),
    .B1    (b1),
    .B2    (b2),
    .B3    (b3),
    .Da    (da),
    .Db    (db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] v);
    we  = 1'b1;
    add = a;
    d   = v;
    tick();
    we  = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    check({tag, "_q0"}, q0, e0);
    check({tag, "_q1"}, q1, e1);
    check({tag, "_q2"}, q2, e2);
    check({tag, "_q3"}, q3, e3);
    check({tag, "_b0"}, b0, e0);
    check({tag, "_b1"}, b1, e1);
    check({tag, "_b2"}, b2, e2);
    check({tag, "_b3"}, b3, e3);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    we    = 1'b0;
    d     = 8'h00;
    add   = 2'd0;
    cha   = 2'd0;
    chb   = 2'd0;

    #1;
    tick();
    tick();
    check_regs("por_reset", 8'h00, 8'h00, 8'h00, 8'h00);

    // Preload nonzero values, then reset with a competing write.
    rst_n = 1'b1;
    write(2'd0, 8'h11);
    write(2'd1, 8'h22);
    write(2'd2, 8'h33);
    write(2'd3, 8'h44);
    check_regs("preload", 8'h11, 8'h22, 8'h33, 8'h44);
    rst_n = 1'b0;
    we    = 1'b1;
    d     = 8'hFF;
    add   = 2'd2;
    cha   = 2'd1;
    chb   = 2'd2;
    tick();
    check_regs("reset_over_we", 8'h00, 8'h00, 8'h00, 8'h00);
    check("reset_da", da, 8'h00);
    check("reset_db", db, 8'h00);
    we    = 1'b0;
    rst_n = 1'b1;

    // Sequential writes on successive edges.
    we = 1'b1;
    add = 2'd0; d = 8'hA0; tick();
    add = 2'd1; d = 8'hB1; tick();
    add = 2'd2; d = 8'hC2; tick();
    add = 2'd3; d = 8'hD3; tick();
    we = 1'b0;
    check_regs("seq_write", 8'hA0, 8'hB1, 8'hC2, 8'hD3);

    // Dual read, combinational address change without an edge.
    cha = 2'd0; chb = 2'd1; #1;
    check("read_a0", da, 8'hA0);
    check("read_b1", db, 8'hB1);
    cha = 2'd2; chb = 2'd3; #1;
    check("read_a2", da, 8'hC2);
    check("read_b3", db, 8'hD3);

    // Hold with WE low while D/add point at Q1.
    d = 8'h55; add = 2'd1;
    tick(); tick(); tick();
    check_regs("hold", 8'hA0, 8'hB1, 8'hC2, 8'hD3);

    // Same register on both ports, then rewrite it.
    cha = 2'd3; chb = 2'd3; #1;
    check("same_a", da, 8'hD3);
    check("same_b", db, 8'hD3);
    write(2'd3, 8'h7E);
    check("same_a_new", da, 8'h7E);
    check("same_b_new", db, 8'h7E);
    check("same_q3", q3, 8'h7E);

    // Read-during-write on port A; port B reads an unrelated register.
    we = 1'b1; add = 2'd0; d = 8'h5A; cha = 2'd0; chb = 2'd1; #1;
`ifdef GPT_DATAREG_BYPASS_EN
    check("rdw_before_da", da, 8'h5A);
`else
    check("rdw_before_da", da, 8'hA0);
`endif
    check("rdw_before_db", db, 8'hB1);
    check("rdw_before_q0", q0, 8'hA0);
    tick();
    we = 1'b0;
    check("rdw_after_da", da, 8'h5A);
    check_regs("rdw_after", 8'h5A, 8'hB1, 8'hC2, 8'h7E);

    // Reset mid-sequence with a write pending, then writes resume.
    rst_n = 1'b0; we = 1'b1; add = 2'd1; d = 8'h99;
    tick();
    check_regs("mid_reset", 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    tick();
    we = 1'b0;
    check_regs("resume", 8'h00, 8'h99, 8'h00, 8'h00);
    cha = 2'd1; chb = 2'd2; #1;
    check("resume_da", da, 8'h99);
    check("resume_db", db, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
